// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address width, PC sequencer defaults and
// the sequencer state type.
package cpu_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_VECTOR_DEF = '0;
  localparam addr_t PC_INC_DEF       = 32'd1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FAULT = 2'd3
  } pc_seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the branch unit (master) and the PC sequencer (slave).
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic  stall;
  logic  br_valid;
  logic  br_link;
  addr_t br_target;
  logic  ret_valid;
  logic  ctl_ready;
  addr_t pc;
  logic  pc_valid;
  logic  ras_empty;
  logic  ras_full;
  logic  fault;

  modport master (
    output stall, br_valid, br_link, br_target, ret_valid,
    input  ctl_ready, pc, pc_valid, ras_empty, ras_full, fault
  );

  modport slave (
    input  stall, br_valid, br_link, br_target, ret_valid,
    output ctl_ready, pc, pc_valid, ras_empty, ras_full, fault
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry
// and the occupancy count saturates at DEPTH.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;

  // ptr is the next free slot; wrap-around is the natural overflow of PW bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  assign top   = mem[ptr - PW'(1)];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential stepping, branch/call redirect with a
// one-cycle flush bubble, return via RAS, sticky fault on return with empty RAS.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter addr_t       RESET_VECTOR = RESET_VECTOR_DEF,
  parameter addr_t       PC_INC       = PC_INC_DEF,
  parameter int unsigned RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_sequencer_if.slave     ctl
);

  pc_seq_state_t state;
  addr_t         pc_q;
  logic          pc_valid_q;
  logic          fault_q;

  logic  accept;
  logic  push;
  logic  pop;
  addr_t ras_top;
  logic  ras_empty;
  logic  ras_full;

  // Return outranks branch; a call that loses to a return must not push.
  always_comb begin
    accept = (state == RUN) && !ctl.stall;
    pop    = accept && ctl.ret_valid && !ras_empty;
    push   = accept && !ctl.ret_valid && ctl.br_valid && ctl.br_link;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (!ctl.stall) begin
            if (ctl.ret_valid) begin
              pc_valid_q <= 1'b0;
              if (!ras_empty) begin
                pc_q  <= ras_top;
                state <= FLUSH;
              end else begin
                fault_q <= 1'b1;
                state   <= FAULT;
              end
            end else if (ctl.br_valid) begin
              pc_q       <= ctl.br_target;
              pc_valid_q <= 1'b0;
              state      <= FLUSH;
            end else begin
              pc_q <= pc_q + PC_INC;
            end
          end
        end
        FLUSH: begin
          state      <= RUN;
          pc_valid_q <= 1'b1;
        end
        FAULT: begin
          state      <= FAULT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + PC_INC),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign ctl.ctl_ready = accept;
  assign ctl.pc        = pc_q;
  assign ctl.pc_valid  = pc_valid_q;
  assign ctl.ras_empty = ras_empty;
  assign ctl.ras_full  = ras_full;
  assign ctl.fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model with a queue-based return stack.
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .PC_INC       (32'd1),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model
  logic [31:0] m_pc;
  logic        m_boot, m_bubble, m_fault;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic m_valid();
    return !m_boot && !m_bubble && !m_fault;
  endfunction

  task automatic model_reset();
    m_pc = RV; m_boot = 1'b1; m_bubble = 1'b0; m_fault = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_update(input logic s, input logic b, input logic l,
                              input logic [31:0] t, input logic r);
    if (m_boot) m_boot = 1'b0;
    else if (m_fault) ;
    else if (m_bubble) m_bubble = 1'b0;
    else if (s) ;
    else if (r) begin
      if (m_ras.size() == 0) m_fault = 1'b1;
      else begin
        m_pc = m_ras.pop_back();
        m_bubble = 1'b1;
      end
    end else if (b) begin
      if (l) begin
        m_ras.push_back(m_pc + 32'd1);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = t;
      m_bubble = 1'b1;
    end else m_pc = m_pc + 32'd1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic s, input logic b, input logic l,
                      input logic [31:0] t, input logic r);
    bus.stall = s; bus.br_valid = b; bus.br_link = l; bus.br_target = t; bus.ret_valid = r;
    #1;
    check("pc",        bus.pc,               m_pc);
    check("pc_valid",  32'(bus.pc_valid),    32'(m_valid()));
    check("ctl_ready", 32'(bus.ctl_ready),   32'(m_valid() && !s));
    check("ras_empty", 32'(bus.ras_empty),   32'(m_ras.size() == 0));
    check("ras_full",  32'(bus.ras_full),    32'(m_ras.size() == DEPTH));
    check("fault",     32'(bus.fault),       32'(m_fault));
    model_update(s, b, l, t, r);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset: outputs must be at reset values before any clock edge.
  task automatic reset_pulse();
    bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_link = 1'b0;
    bus.br_target = '0; bus.ret_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_pc",        bus.pc,              RV);
    check("rst_pc_valid",  32'(bus.pc_valid),   32'd0);
    check("rst_ctl_ready", 32'(bus.ctl_ready),  32'd0);
    check("rst_ras_empty", 32'(bus.ras_empty),  32'd1);
    check("rst_ras_full",  32'(bus.ras_full),   32'd0);
    check("rst_fault",     32'(bus.fault),      32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input logic [31:0] target);
    for (int i = 0; i < 64; i++) begin
      if (m_pc == target && m_valid()) break;
      idle();
    end
    check("run_to", bus.pc, target);
  endtask

  initial begin
    bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_link = 1'b0;
    bus.br_target = '0; bus.ret_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset_pulse();

    // Boot bubble then sequential stepping
    repeat (4) idle();
    run_to(32'h5);
    step(1'b0, 1'b1, 1'b0, 32'h100, 1'b0);
    check("br_redirect_pc", bus.pc, 32'h100);
    check("br_bubble",      32'(bus.pc_valid), 32'd0);
    repeat (2) idle();

    // Call then return
    step(1'b0, 1'b1, 1'b0, 32'h10, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    idle();
    run_to(32'h42);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    check("ret_pc",    bus.pc, 32'h11);
    check("ret_empty", 32'(bus.ras_empty), 32'd1);

    // RAS overflow: five calls into a four-deep stack
    reset_pulse();
    run_to(32'h0);
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, m_pc + 32'h10, 1'b0);
      idle();
    end
    check("ovf_full", 32'(bus.ras_full), 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      idle();
      check("ovf_ret_pc", bus.pc, 32'h41 - 32'(i) * 32'h10);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("underflow_fault", 32'(bus.fault),    32'd1);
    check("underflow_pc",    bus.pc,            32'h11);
    repeat (2) idle();
    reset_pulse();

    // Stall holds a pending branch until release; then PC wrap
    repeat (3) idle();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h200, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h200, 1'b0);
    check("stall_release_pc", bus.pc, 32'h200);
    idle();
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    repeat (3) idle();
    check("wrap_pc", bus.pc, 32'h0);
    idle();

    // Reset during the flush bubble
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
    reset_pulse();

    // Simultaneous call and return: return wins, call not pushed
    repeat (2) idle();
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b1, 32'h500, 1'b1);
    check("both_no_push", 32'(bus.ras_empty), 32'd1);
    idle();
    step(1'b0, 1'b1, 1'b1, 32'h600, 1'b1);
    check("both_empty_fault", 32'(bus.fault), 32'd1);
    idle();

    // Random traffic
    for (int unsigned i = 0; i < 800; i++) begin
      if ($urandom_range(99) < (m_fault ? 30 : 1)) reset_pulse();
      else step($urandom_range(99) < 25, $urandom_range(99) < 30, $urandom_range(1) == 1,
                $urandom, $urandom_range(99) < 20);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
